// File: rtl/flag_order_ctrl_if.sv
// Bus between the HUD flag-order controller and its surroundings: line count,
// player/round controls in, pattern selects and animation status out.
interface flag_order_ctrl_if;
    logic [9:0] v_cnt;
    logic       p1_btn;
    logic       p2_btn;
    logic       shuffle_req;
    logic       lock;
    logic [1:0] p1_order;
    logic [1:0] p2_order;
    logic       flag_vis;
    logic       busy;
    logic       done;

    modport master (
        output v_cnt, p1_btn, p2_btn, shuffle_req, lock,
        input  p1_order, p2_order, flag_vis, busy, done
    );

    modport slave (
        input  v_cnt, p1_btn, p2_btn, shuffle_req, lock,
        output p1_order, p2_order, flag_vis, busy, done
    );
endinterface

// File: rtl/flag_order_ctrl.sv
// Owns the P1/P2 flag-card pattern selects; steps them on button presses and runs
// the round-start shuffle animation, changing orders only on vertical-blank entry.
module flag_order_ctrl #(
    parameter int          V_ACTIVE       = 480,
    parameter int          SHUFFLE_FRAMES = 32,
    parameter int          BLINK_FRAMES   = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic               clk,
    input logic               rst_n,
    flag_order_ctrl_if.slave  bus
);

    localparam int FW = $clog2(SHUFFLE_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [9:0]    V_ACTIVE_L = 10'(V_ACTIVE);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SHUFFLE_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic {
        IDLE,
        SHUFFLE
    } state_e;

    state_e        state_q, state_d;
    logic          vb_q;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [1:0]    p1_q, p1_d;
    logic [1:0]    p2_q, p2_d;
    logic          pend1_q, pend1_d;
    logic          pend2_q, pend2_d;
    logic          vis_q, vis_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [BW-1:0] blink_q, blink_d;

    logic vblank;
    logic vb_edge;
    logic press1;
    logic press2;

    assign vblank  = (bus.v_cnt >= V_ACTIVE_L);
    assign vb_edge = vblank & ~vb_q;
    assign press1  = bus.p1_btn & ~bus.lock;
    assign press2  = bus.p2_btn & ~bus.lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vb_q    <= 1'b1;
            lfsr_q  <= LFSR_SEED;
            p1_q    <= 2'd0;
            p2_q    <= 2'd0;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            vis_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            frame_q <= '0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            vb_q    <= vblank;
            lfsr_q  <= lfsr_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            vis_q   <= vis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        p1_d    = p1_q;
        p2_d    = p2_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        vis_d   = vis_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        frame_d = frame_q;
        blink_d = blink_q;

        case (state_q)
            IDLE: begin
                // A shuffle start discards any queued or same-cycle presses.
                if (bus.shuffle_req && !bus.lock) begin
                    state_d = SHUFFLE;
                    pend1_d = 1'b0;
                    pend2_d = 1'b0;
                    frame_d = '0;
                    blink_d = '0;
                    busy_d  = 1'b1;
                end else if (vb_edge) begin
                    if (pend1_q || press1) p1_d = p1_q + 2'd1;
                    if (pend2_q || press2) p2_d = p2_q + 2'd1;
                    pend1_d = 1'b0;
                    pend2_d = 1'b0;
                end else begin
                    pend1_d = pend1_q | press1;
                    pend2_d = pend2_q | press2;
                end
            end

            SHUFFLE: begin
                if (vb_edge) begin
                    p1_d = lfsr_q[1:0];
                    p2_d = lfsr_q[3:2];
                    if (frame_q == FRAME_LAST) begin
                        state_d = IDLE;
                        vis_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        frame_d = frame_q + FW'(1);
                        if (blink_q == BLINK_LAST) begin
                            blink_d = '0;
                            vis_d   = ~vis_q;
                        end else begin
                            blink_d = blink_q + BW'(1);
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.p1_order = p1_q;
    assign bus.p2_order = p2_q;
    assign bus.flag_vis = vis_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_flag_order_ctrl.sv
// Directed bench for flag_order_ctrl: button stepping, lock behaviour, the shuffle
// animation (short parameters) and reset in the middle of a shuffle.
module tb_flag_order_ctrl;

    localparam int          V_ACTIVE       = 480;
    localparam int          SHUFFLE_FRAMES = 4;
    localparam int          BLINK_FRAMES   = 2;
    localparam logic [15:0] LFSR_SEED      = 16'hACE1;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    int   doneSeen;
    int   cyc;

    flag_order_ctrl_if bus ();

    flag_order_ctrl #(
        .V_ACTIVE       (V_ACTIVE),
        .SHUFFLE_FRAMES (SHUFFLE_FRAMES),
        .BLINK_FRAMES   (BLINK_FRAMES),
        .LFSR_SEED      (LFSR_SEED)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of rising edges since reset release = number of LFSR shifts so far.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) doneSeen++;
    end

    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] v;
        v = LFSR_SEED;
        for (int i = 0; i < n; i++) v = {v[14:0], ^(v & 16'hB400)};
        return v;
    endfunction

    // All stimulus tasks are entered and left just after a falling edge.
    task automatic run_active(input int n);
        bus.v_cnt = 10'd100;
        repeat (n) @(negedge clk);
    endtask

    task automatic enter_vblank(output logic [15:0] expLfsr);
        bus.v_cnt = 10'(V_ACTIVE);
        expLfsr = lfsr_after(cyc);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] unused;
        int          doneBefore;
        bus.v_cnt = 10'd0;
        bus.p1_btn = 1'b0;
        bus.p2_btn = 1'b0;
        bus.shuffle_req = 1'b0;
        bus.lock = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkCount++;
        if (bus.p1_order !== 2'd0 || bus.p2_order !== 2'd0 || bus.flag_vis !== 1'b1 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("[TB] FAIL reset_values: got p1=%0d p2=%0d vis=%0b busy=%0b done=%0b, want 0 0 1 0 0",
                     bus.p1_order, bus.p2_order, bus.flag_vis, bus.busy, bus.done);
        else passCount++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneBefore = doneSeen;
        for (int f = 0; f < 2; f++) begin
            run_active(3);
            enter_vblank(unused);
            @(negedge clk);
        end
        checkCount++;
        if (bus.p1_order !== 2'd0) $display("[TB] FAIL idle_p1: got %0d want 0", bus.p1_order);
        else passCount++;
        checkCount++;
        if (bus.p2_order !== 2'd0) $display("[TB] FAIL idle_p2: got %0d want 0", bus.p2_order);
        else passCount++;
        checkCount++;
        if (bus.flag_vis !== 1'b1 || bus.busy !== 1'b0)
            $display("[TB] FAIL idle_vis_busy: got vis=%0b busy=%0b want 1 0", bus.flag_vis, bus.busy);
        else passCount++;
        checkCount++;
        if (doneSeen !== doneBefore) $display("[TB] FAIL idle_no_done: got %0d pulses want 0", doneSeen - doneBefore);
        else passCount++;
    endtask

    task automatic test_p1_absorb();
        logic [15:0] unused;
        run_active(2);
        for (int i = 0; i < 3; i++) begin
            bus.p1_btn = 1'b1;
            @(negedge clk);
            bus.p1_btn = 1'b0;
            @(negedge clk);
        end
        checkCount++;
        if (bus.p1_order !== 2'd0) $display("[TB] FAIL p1_before_edge: got %0d want 0", bus.p1_order);
        else passCount++;
        enter_vblank(unused);
        checkCount++;
        if (bus.p1_order !== 2'd1) $display("[TB] FAIL p1_after_edge: got %0d want 1", bus.p1_order);
        else passCount++;
        checkCount++;
        if (bus.p2_order !== 2'd0) $display("[TB] FAIL p2_untouched: got %0d want 0", bus.p2_order);
        else passCount++;
    endtask

    task automatic test_p2_wrap();
        logic [15:0] unused;
        logic [1:0]  expP2 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int f = 0; f < 4; f++) begin
            run_active(2);
            bus.p2_btn = 1'b1;
            @(negedge clk);
            bus.p2_btn = 1'b0;
            @(negedge clk);
            enter_vblank(unused);
            checkCount++;
            if (bus.p2_order !== expP2[f])
                $display("[TB] FAIL p2_wrap[%0d]: got %0d want %0d", f, bus.p2_order, expP2[f]);
            else passCount++;
        end
    endtask

    task automatic test_lock();
        logic [15:0] unused;
        run_active(2);
        bus.p2_btn = 1'b1;
        @(negedge clk);
        bus.p2_btn = 1'b0;
        bus.lock = 1'b1;
        bus.p1_btn = 1'b1;
        @(negedge clk);
        bus.p1_btn = 1'b0;
        @(negedge clk);
        enter_vblank(unused);
        checkCount++;
        if (bus.p1_order !== 2'd1) $display("[TB] FAIL lock_p1_frozen: got %0d want 1", bus.p1_order);
        else passCount++;
        checkCount++;
        if (bus.p2_order !== 2'd1) $display("[TB] FAIL lock_keeps_pend: got %0d want 1", bus.p2_order);
        else passCount++;
        run_active(2);
        bus.shuffle_req = 1'b1;
        @(negedge clk);
        bus.shuffle_req = 1'b0;
        @(negedge clk);
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL lock_blocks_shuffle: got busy=%0b want 0", bus.busy);
        else passCount++;
        bus.lock = 1'b0;
    endtask

    task automatic test_shuffle();
        logic [15:0] expLfsr;
        logic        expVis  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        expBusy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        expDone [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          doneBefore;
        run_active(2);
        doneBefore = doneSeen;
        bus.shuffle_req = 1'b1;
        @(negedge clk);
        bus.shuffle_req = 1'b0;
        for (int f = 0; f < SHUFFLE_FRAMES; f++) begin
            run_active(3);
            enter_vblank(expLfsr);
            checkCount++;
            if (bus.flag_vis !== expVis[f])
                $display("[TB] FAIL shuffle_vis[%0d]: got %0b want %0b", f, bus.flag_vis, expVis[f]);
            else passCount++;
            checkCount++;
            if (bus.busy !== expBusy[f])
                $display("[TB] FAIL shuffle_busy[%0d]: got %0b want %0b", f, bus.busy, expBusy[f]);
            else passCount++;
            checkCount++;
            if (bus.done !== expDone[f])
                $display("[TB] FAIL shuffle_done[%0d]: got %0b want %0b", f, bus.done, expDone[f]);
            else passCount++;
            checkCount++;
            if (bus.p1_order !== expLfsr[1:0])
                $display("[TB] FAIL shuffle_p1[%0d]: got %0d want %0d", f, bus.p1_order, expLfsr[1:0]);
            else passCount++;
            checkCount++;
            if (bus.p2_order !== expLfsr[3:2])
                $display("[TB] FAIL shuffle_p2[%0d]: got %0d want %0d", f, bus.p2_order, expLfsr[3:2]);
            else passCount++;
        end
        @(negedge clk);
        checkCount++;
        if (bus.done !== 1'b0) $display("[TB] FAIL done_one_cycle: got %0b want 0", bus.done);
        else passCount++;
        checkCount++;
        if (doneSeen - doneBefore !== 1)
            $display("[TB] FAIL done_count: got %0d pulses want 1", doneSeen - doneBefore);
        else passCount++;
    endtask

    task automatic test_shuffle_priority();
        logic [15:0] expLfsr;
        logic [15:0] unused;
        run_active(2);
        bus.shuffle_req = 1'b1;
        bus.p1_btn = 1'b1;
        @(negedge clk);
        bus.shuffle_req = 1'b0;
        bus.p1_btn = 1'b0;
        checkCount++;
        if (bus.busy !== 1'b1) $display("[TB] FAIL prio_busy: got %0b want 1", bus.busy);
        else passCount++;
        for (int f = 0; f < SHUFFLE_FRAMES; f++) begin
            run_active(2);
            enter_vblank(expLfsr);
        end
        checkCount++;
        if (bus.p1_order !== expLfsr[1:0])
            $display("[TB] FAIL prio_final_p1: got %0d want %0d", bus.p1_order, expLfsr[1:0]);
        else passCount++;
        run_active(3);
        enter_vblank(unused);
        checkCount++;
        if (bus.p1_order !== expLfsr[1:0])
            $display("[TB] FAIL prio_press_dropped: got %0d want %0d", bus.p1_order, expLfsr[1:0]);
        else passCount++;
    endtask

    task automatic test_reset_mid_shuffle();
        logic [15:0] unused;
        int          doneBefore;
        run_active(2);
        doneBefore = doneSeen;
        bus.shuffle_req = 1'b1;
        bus.p1_btn = 1'b1;
        @(negedge clk);
        bus.shuffle_req = 1'b0;
        bus.p1_btn = 1'b0;
        for (int f = 0; f < 2; f++) begin
            run_active(2);
            enter_vblank(unused);
        end
        checkCount++;
        if (bus.busy !== 1'b1) $display("[TB] FAIL midshuffle_busy: got %0b want 1", bus.busy);
        else passCount++;
        #2 rst_n = 1'b0;
        #1;
        checkCount++;
        if (bus.busy !== 1'b0 || bus.p1_order !== 2'd0 || bus.p2_order !== 2'd0 ||
            bus.flag_vis !== 1'b1 || bus.done !== 1'b0)
            $display("[TB] FAIL midshuffle_reset: got busy=%0b p1=%0d p2=%0d vis=%0b done=%0b, want 0 0 0 1 0",
                     bus.busy, bus.p1_order, bus.p2_order, bus.flag_vis, bus.done);
        else passCount++;
        @(negedge clk);
        bus.v_cnt = 10'd100;
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            run_active(3);
            enter_vblank(unused);
        end
        checkCount++;
        if (bus.p1_order !== 2'd0 || bus.busy !== 1'b0)
            $display("[TB] FAIL after_reset_idle: got p1=%0d busy=%0b want 0 0", bus.p1_order, bus.busy);
        else passCount++;
        checkCount++;
        if (doneSeen !== doneBefore)
            $display("[TB] FAIL reset_no_done: got %0d pulses want 0", doneSeen - doneBefore);
        else passCount++;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        doneSeen   = 0;
        test_reset();
        test_p1_absorb();
        test_p2_wrap();
        test_lock();
        test_shuffle();
        test_shuffle_priority();
        test_reset_mid_shuffle();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
